branch_sequencer: RTL and testbench

- Consumes the branch-logic outputs (cond, BA_O, BN_O) together with the instruction fields of the current IR and owns the architectural PC/nPC pair.
- Implements SPARC V8 delayed control transfer for Bicc: target computation, the PC<=nPC / nPC<=next rule, and delay-slot annulment.
- Sits directly downstream of the branch-condition block and replaces the ad-hoc PC_In_Mux/NPC sequencing the control unit does today.

---
 rtl/sparc_pkg.sv | 16 +
 rtl/branch_target_adder.sv | 11 +
 rtl/branch_sequencer.sv | 132 +++++++++++++
 tb/tb_branch_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_pkg.sv
// Shared SPARC V8 sequencing definitions: FSM states, format-2 Bicc decode fields, cond codes.
package sparc_pkg;

  typedef enum logic {RUN, RESOLVE} seq_state_t;

  localparam logic [1:0] OP_FMT2  = 2'b00;
  localparam logic [2:0] OP2_BICC = 3'b010;

  localparam logic [3:0] COND_BN = 4'b0000;
  localparam logic [3:0] COND_BA = 4'b1000;

  function automatic logic is_bicc(input logic [1:0] op, input logic [2:0] op2);
    return (op == OP_FMT2) && (op2 == OP2_BICC);
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Bicc target: pc + (sign-extended disp22 << 2), wrapping mod 2^32.
// Purely combinational, no flow control.
module branch_target_adder (
  input  logic [31:0] base_pc,
  input  logic [21:0] disp22,
  output logic [31:0] target
);

  assign target = base_pc + {{8{disp22[21]}}, disp22, 2'b00};

endmodule

// File: rtl/branch_sequencer.sv
// SPARC V8 PC/nPC sequencer for Bicc with delay-slot annulment; commits one edge after step (done).
// Steps during RESOLVE are dropped. Optional taken/annulled counters under BRANCH_STATS_EN.
module branch_sequencer
  import sparc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] RESET_NPC = 32'h0000_0004
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        step,
  input  logic [1:0]  ir_op,
  input  logic [2:0]  ir_op2,
  input  logic        ir_a,
  input  logic [21:0] ir_disp22,
  input  logic        cond,
  input  logic        ba,
  input  logic        bn,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_taken,
  output logic [31:0] stat_annulled,
`endif
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        annul_slot,
  output logic        taken,
  output logic        done
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d;
  logic        annul_q, annul_d, taken_q, taken_d, done_q, done_d;

  logic        s_bicc, s_a, s_cond, s_ba, s_bn;
  logic [21:0] s_disp;
  logic [31:0] target;

  // pc is stable through RESOLVE, so the target can be formed from the live pc.
  branch_target_adder u_target (
    .base_pc (pc_q),
    .disp22  (s_disp),
    .target  (target)
  );

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_NPC;
      annul_q <= 1'b0;
      taken_q <= 1'b0;
      done_q  <= 1'b0;
      s_bicc  <= 1'b0;
      s_a     <= 1'b0;
      s_cond  <= 1'b0;
      s_ba    <= 1'b0;
      s_bn    <= 1'b0;
      s_disp  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      annul_q <= annul_d;
      taken_q <= taken_d;
      done_q  <= done_d;
      if (state_q == RUN && step) begin
        s_bicc <= is_bicc(ir_op, ir_op2);
        s_a    <= ir_a;
        s_cond <= cond;
        s_ba   <= ba;
        s_bn   <= bn;
        s_disp <= ir_disp22;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    annul_d = annul_q;
    taken_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (step) state_d = RESOLVE;
      end
      RESOLVE: begin
        state_d = RUN;
        done_d  = 1'b1;
        pc_d    = npc_q;
        npc_d   = npc_q + 32'd4;
        annul_d = 1'b0;
        // A squashed slot ignores its own fields entirely.
        if (!annul_q && s_bicc) begin
          if (s_cond && !s_bn) begin
            npc_d   = target;
            taken_d = 1'b1;
            annul_d = s_ba && s_a;
          end else begin
            annul_d = s_a;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign pc         = pc_q;
  assign npc        = npc_q;
  assign annul_slot = annul_q;
  assign taken      = taken_q;
  assign done       = done_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] cnt_taken_q, cnt_annul_q;

  always_ff @(posedge Clk) begin
    if (RESET) begin
      cnt_taken_q <= '0;
      cnt_annul_q <= '0;
    end else if (state_q == RESOLVE) begin
      if (taken_d && cnt_taken_q != 32'hFFFF_FFFF) cnt_taken_q <= cnt_taken_q + 32'd1;
      if (annul_q && cnt_annul_q != 32'hFFFF_FFFF) cnt_annul_q <= cnt_annul_q + 32'd1;
    end
  end

  assign stat_taken    = cnt_taken_q;
  assign stat_annulled = cnt_annul_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, randomized steps vs. a reference model.
module tb_branch_sequencer;

  logic        Clk = 1'b0;
  logic        RESET = 1'b0;
  logic        step = 1'b0;
  logic [1:0]  ir_op = 2'b10;
  logic [2:0]  ir_op2 = 3'b000;
  logic        ir_a = 1'b0;
  logic [21:0] ir_disp22 = '0;
  logic        cond = 1'b0, ba = 1'b0, bn = 1'b0;
  logic [31:0] pc, npc;
  logic        annul_slot, taken, done;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken, stat_annulled;
`endif

  branch_sequencer dut (
    .Clk(Clk), .RESET(RESET), .step(step),
    .ir_op(ir_op), .ir_op2(ir_op2), .ir_a(ir_a), .ir_disp22(ir_disp22),
    .cond(cond), .ba(ba), .bn(bn),
`ifdef BRANCH_STATS_EN
    .stat_taken(stat_taken), .stat_annulled(stat_annulled),
`endif
    .pc(pc), .npc(npc), .annul_slot(annul_slot), .taken(taken), .done(done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference architectural state.
  logic [31:0] m_pc, m_npc, m_stat_t, m_stat_a;
  logic        m_ann, m_taken;

  typedef struct {
    logic        rst;
    logic [1:0]  op;
    logic [2:0]  op2;
    logic        a;
    logic [21:0] disp;
    logic        c, b_a, b_n;
    logic [31:0] e_pc, e_npc;
    logic        e_ann, e_taken;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [1:0] op, logic [2:0] op2, logic a,
                              logic [21:0] disp, logic c, logic b_a, logic b_n,
                              logic [31:0] e_pc, logic [31:0] e_npc, logic e_ann, logic e_taken);
    vec_t v;
    v.rst = rst; v.op = op; v.op2 = op2; v.a = a; v.disp = disp;
    v.c = c; v.b_a = b_a; v.b_n = b_n;
    v.e_pc = e_pc; v.e_npc = e_npc; v.e_ann = e_ann; v.e_taken = e_taken;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_npc = 32'h4; m_ann = 1'b0; m_taken = 1'b0;
    m_stat_t = 0; m_stat_a = 0;
  endtask

  task automatic model_step(logic [1:0] op, logic [2:0] op2, logic a, logic [21:0] disp,
                            logic c, logic b_a, logic b_n);
    logic [31:0] old_pc;
    logic signed [21:0] sd;
    int off;
    old_pc = m_pc;
    sd = disp;
    off = int'(sd) * 4;
    m_pc = m_npc;
    m_taken = 1'b0;
    if (m_ann) begin
      m_npc = m_npc + 4;
      m_ann = 1'b0;
      if (m_stat_a != 32'hFFFF_FFFF) m_stat_a++;
    end else if (op == 2'b00 && op2 == 3'b010) begin
      if (c && !b_n) begin
        m_npc = old_pc + 32'(off);
        m_taken = 1'b1;
        m_ann = b_a && a;
        if (m_stat_t != 32'hFFFF_FFFF) m_stat_t++;
      end else begin
        m_npc = m_npc + 4;
        m_ann = a;
      end
    end else begin
      m_npc = m_npc + 4;
      m_ann = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk); RESET = 1'b1;
    @(negedge Clk); RESET = 1'b0;
    model_reset();
  endtask

  // Drive one step; returns at the negedge after the commit edge.
  task automatic do_step(logic [1:0] op, logic [2:0] op2, logic a, logic [21:0] disp,
                         logic c, logic b_a, logic b_n);
    @(negedge Clk);
    ir_op = op; ir_op2 = op2; ir_a = a; ir_disp22 = disp; cond = c; ba = b_a; bn = b_n;
    step = 1'b1;
    @(negedge Clk);
    step = 1'b0;
    ir_op = 2'b10; ir_disp22 = 22'h155555; cond = ~c; ba = 1'b0; bn = 1'b0;
    @(negedge Clk);
    model_step(op, op2, a, disp, c, b_a, b_n);
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".npc"}, npc, m_npc);
    chk({tag, ".annul"}, {31'b0, annul_slot}, {31'b0, m_ann});
    chk({tag, ".taken"}, {31'b0, taken}, {31'b0, m_taken});
    chk({tag, ".done"}, {31'b0, done}, 32'd1);
`ifdef BRANCH_STATS_EN
    chk({tag, ".stat_taken"}, stat_taken, m_stat_t);
    chk({tag, ".stat_annulled"}, stat_annulled, m_stat_a);
`endif
  endtask

  vec_t vecs[16];

  initial begin
    model_reset();
    vecs[0]  = mk(1, 2'b10, 3'b000, 0, 22'd0,       0, 0, 0, 32'd4,  32'd8,  0, 0);
    vecs[1]  = mk(1, 2'b00, 3'b010, 0, 22'd3,       1, 1, 0, 32'd4,  32'd12, 0, 1);
    vecs[2]  = mk(0, 2'b10, 3'b000, 0, 22'd0,       0, 0, 0, 32'd12, 32'd16, 0, 0);
    vecs[3]  = mk(1, 2'b00, 3'b010, 1, 22'd3,       1, 1, 0, 32'd4,  32'd12, 1, 1);
    vecs[4]  = mk(0, 2'b00, 3'b010, 0, 22'd5,       1, 1, 0, 32'd12, 32'd16, 0, 0);
    vecs[5]  = mk(1, 2'b00, 3'b010, 1, 22'd3,       0, 0, 1, 32'd4,  32'd8,  1, 0);
    vecs[6]  = mk(0, 2'b10, 3'b000, 0, 22'd0,       0, 0, 0, 32'd8,  32'd12, 0, 0);
    vecs[7]  = mk(1, 2'b00, 3'b010, 0, 22'd3,       0, 0, 1, 32'd4,  32'd8,  0, 0);
    vecs[8]  = mk(0, 2'b10, 3'b000, 0, 22'd0,       0, 0, 0, 32'd8,  32'd12, 0, 0);
    vecs[9]  = mk(0, 2'b00, 3'b010, 0, 22'h3FFFFF,  0, 0, 0, 32'd12, 32'd16, 0, 0);
    vecs[10] = mk(1, 2'b10, 3'b000, 0, 22'd0,       0, 0, 0, 32'd4,  32'd8,  0, 0);
    vecs[11] = mk(0, 2'b10, 3'b000, 0, 22'd0,       0, 0, 0, 32'd8,  32'd12, 0, 0);
    vecs[12] = mk(0, 2'b00, 3'b010, 0, 22'h3FFFFF,  1, 0, 0, 32'd12, 32'd4,  0, 1);
    vecs[13] = mk(0, 2'b00, 3'b010, 0, 22'd2,       1, 0, 0, 32'd4,  32'd20, 0, 1);
    vecs[14] = mk(0, 2'b10, 3'b000, 0, 22'd0,       0, 0, 0, 32'd20, 32'd24, 0, 0);
    vecs[15] = mk(1, 2'b00, 3'b010, 1, 22'd7,       1, 1, 1, 32'd4,  32'd8,  1, 0);

    do_reset();
    chk("reset.pc", pc, 32'h0);
    chk("reset.npc", npc, 32'h4);
    chk("reset.annul", {31'b0, annul_slot}, 32'd0);
    chk("reset.taken", {31'b0, taken}, 32'd0);
    chk("reset.done", {31'b0, done}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst) do_reset();
      do_step(vecs[i].op, vecs[i].op2, vecs[i].a, vecs[i].disp, vecs[i].c, vecs[i].b_a, vecs[i].b_n);
      chk($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.npc", i), npc, vecs[i].e_npc);
      chk($sformatf("vec%0d.annul", i), {31'b0, annul_slot}, {31'b0, vecs[i].e_ann});
      chk($sformatf("vec%0d.taken", i), {31'b0, taken}, {31'b0, vecs[i].e_taken});
      chk($sformatf("vec%0d.done", i), {31'b0, done}, 32'd1);
      @(negedge Clk);
      chk($sformatf("vec%0d.done_drop", i), {31'b0, done}, 32'd0);
    end

    // Reset in the RESOLVE cycle discards the pending update.
    do_reset();
    do_step(2'b10, 3'b000, 0, 22'd0, 0, 0, 0);
    @(negedge Clk);
    ir_op = 2'b00; ir_op2 = 3'b010; ir_disp22 = 22'd9; cond = 1'b1; ba = 1'b1; step = 1'b1;
    @(negedge Clk);
    step = 1'b0; RESET = 1'b1;
    @(negedge Clk);
    RESET = 1'b0;
    model_reset();
    chk("rst_resolve.pc", pc, 32'h0);
    chk("rst_resolve.npc", npc, 32'h4);
    chk("rst_resolve.done", {31'b0, done}, 32'd0);
    chk("rst_resolve.taken", {31'b0, taken}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("rst_resolve.stat_taken", stat_taken, 32'd0);
    chk("rst_resolve.stat_annulled", stat_annulled, 32'd0);
`endif
    @(negedge Clk);
    chk("rst_resolve.idle_done", {31'b0, done}, 32'd0);
    do_step(2'b10, 3'b000, 0, 22'd0, 0, 0, 0);
    chk_model("after_rst_resolve");

    // Reset wins over a simultaneous step.
    @(negedge Clk);
    RESET = 1'b1; step = 1'b1; ir_op = 2'b10;
    @(negedge Clk);
    RESET = 1'b0; step = 1'b0;
    model_reset();
    @(negedge Clk);
    chk("rst_step.done", {31'b0, done}, 32'd0);
    chk("rst_step.pc", pc, 32'h0);

    // A step held into RESOLVE is dropped: only one commit.
    @(negedge Clk);
    ir_op = 2'b10; step = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    step = 1'b0;
    model_step(2'b10, 3'b000, 0, 22'd0, 0, 0, 0);
    chk("hold_step.pc", pc, m_pc);
    chk("hold_step.done", {31'b0, done}, 32'd1);
    @(negedge Clk);
    chk("hold_step.no_second_done", {31'b0, done}, 32'd0);
    chk("hold_step.pc_stable", pc, m_pc);

    // Randomized steps against the reference model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [1:0] r_op;
      logic [2:0] r_op2;
      logic r_a, r_c, r_ba, r_bn;
      logic [21:0] r_disp;
      int kind;
      if ($urandom_range(0, 39) == 0) do_reset();
      r_op  = ($urandom_range(0, 3) != 0) ? 2'b00 : 2'($urandom);
      r_op2 = ($urandom_range(0, 3) != 0) ? 3'b010 : 3'($urandom);
      r_a   = 1'($urandom);
      r_disp = ($urandom_range(0, 1) != 0) ? 22'($urandom_range(0, 64)) - 22'd32 : 22'($urandom);
      kind  = $urandom_range(0, 9);
      r_ba  = (kind == 0) || (kind == 9);
      r_bn  = (kind == 1) || (kind == 9);
      r_c   = r_ba ? 1'b1 : (r_bn ? 1'b0 : 1'($urandom));
      do_step(r_op, r_op2, r_a, r_disp, r_c, r_ba, r_bn);
      chk_model($sformatf("rand%0d", n));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge Clk);
        chk($sformatf("rand%0d.idle_done", n), {31'b0, done}, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
